sprite_anim_sequencer: RTL and testbench
========================================

Name: sprite_anim_sequencer

Overview:
Per-character animation controller sitting between player logic and the sprite ROM address generator. Selects the active animation clip from the requested action and derives the animation tick from the video frame pulse. Steps through that clip's sprite-sheet cells and outputs the current cell's row/col origin. Replaces the per-clip free-running FSMs with one sequencer that arbitrates clip changes, one-shot locks and holds.

Parameters:
FRAMES_PER_TICK, 6, video frames per animation step (range 1..31)
CELL_W, 23, sprite cell width in pixels; col = frame_idx * CELL_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
frame_start  in  1  one-clk pulse per video frame (vsync edge)
action_req  in  3  requested action: 0 IDLE, 1 WALK, 2 JUMP, 3 FALL, 4 ATTACK; 5-7 treated as IDLE
anim_row  out  8  sprite-sheet row origin of current cell, registered
anim_col  out  8  sprite-sheet col origin of current cell, registered
anim_tick  out  1  one-clk pulse on each animation step
anim_done  out  1  one-clk pulse when a one-shot clip plays its last frame to completion
busy  out  1  high while ATTACK lock is active

Behaviour:
- Single clock; reset is synchronous, active-high, sampled every clk edge and not gated by tick. Reset values: anim_row=0, anim_col=0, anim_tick=0, anim_done=0, busy=0, state=S_RUN, clip=IDLE, frame_idx=0, tick_cnt=0.
- Clip table (row, frames, mode): IDLE (0, 2, loop); WALK (30, 4, loop); JUMP (150, 2, hold-last); FALL (180, 2, loop); ATTACK (60, 3, lock).
- Tick divider: tick_cnt (5b) increments on frame_start. When frame_start && tick_cnt==FRAMES_PER_TICK-1, tick_cnt<=0 and anim_tick pulses on the next clk. FRAMES_PER_TICK=1 gives one tick per frame_start.
- clip_change = (decoded action_req != clip) while not in S_LOCK. On clip_change: clip<=new, frame_idx<=0, tick_cnt<=0, and no tick that cycle. Clip change beats a coincident tick.
- States:
  - S_RUN: on tick, frame_idx advances. Loop clips wrap from frames-1 to 0. JUMP at frame 1 goes to S_HOLD and pulses anim_done. Entering ATTACK goes to S_LOCK with busy=1.
  - S_HOLD: frame_idx frozen at last frame; ticks ignored. Any clip_change returns to S_RUN with the new clip.
  - S_LOCK: action_req ignored. On tick, frame_idx advances. A tick at frame_idx==2 pulses anim_done, clears busy, goes to S_RUN, and loads the current action_req clip at frame 0. If that request is ATTACK, the lock re-enters immediately.
- Outputs are registered. anim_row/anim_col reflect the new clip/frame one clk after the causing edge: anim_row=table row, anim_col=frame_idx*CELL_W (max 3*23=69).
- Reset mid-lock or mid-hold: immediate return to IDLE frame 0 with busy=0.

Optional Feature:
ANIM_FLIP_EN
- Defined: adds input facing_left (1b) and output anim_flip (1b, reset 0). anim_flip samples facing_left only on anim_tick or clip_change, so mirroring never changes mid-cell.
- Undefined: neither port exists and no flip logic is built.

Decomposition:
- Package sprite_anim_pkg holds the action_t enum (3b), seq_state_t enum {S_RUN, S_HOLD, S_LOCK}, clip mode enum {LOOP, HOLD, LOCK}, and the clip table as constant functions clip_row(), clip_frames() and clip_mode().
- One sub-module, anim_tick_div: the frame_start divider with a synchronous clear input, outputting anim_tick.

Test Plan:
- Reset, IDLE held, FRAMES_PER_TICK=6, 24 frame_start pulses -> 4 ticks; col sequence 0,23,0,23; row 0 throughout.
- WALK requested -> next clk row=30, col=0; after 4 ticks col sequence 23,46,69,0.
- JUMP requested -> row=150, col 0 then 23, anim_done pulses once; further ticks leave col=23; then FALL requested -> row=180, col=0.
- ATTACK requested, then WALK after 1 tick -> busy=1, row stays 60, col 23 then 46; on the 3rd tick anim_done pulses, busy=0, row=30, col=0.
- clip_change and tick in the same clk -> col=0 and no anim_tick pulse that cycle; reset asserted during S_LOCK -> next clk row=0, col=0, busy=0.
- With ANIM_FLIP_EN defined, toggle facing_left between ticks -> anim_flip changes only in the cycle after the next tick or clip change.

Source files
------------

// File: rtl/sprite_anim_sequencer_pkg.sv
// Shared types and clip table for the sprite animation sequencer.
package sprite_anim_pkg;

  typedef enum logic [2:0] {
    ACT_IDLE   = 3'd0,
    ACT_WALK   = 3'd1,
    ACT_JUMP   = 3'd2,
    ACT_FALL   = 3'd3,
    ACT_ATTACK = 3'd4
  } action_t;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOLD = 2'd1,
    S_LOCK = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    LOOP = 2'd0,
    HOLD = 2'd1,
    LOCK = 2'd2
  } clip_mode_t;

  // Unused encodings 5-7 fall back to IDLE.
  function automatic action_t decode_action(input logic [2:0] req);
    case (req)
      3'd1:    return ACT_WALK;
      3'd2:    return ACT_JUMP;
      3'd3:    return ACT_FALL;
      3'd4:    return ACT_ATTACK;
      default: return ACT_IDLE;
    endcase
  endfunction

  function automatic logic [7:0] clip_row(input action_t clip);
    case (clip)
      ACT_WALK:   return 8'd30;
      ACT_JUMP:   return 8'd150;
      ACT_FALL:   return 8'd180;
      ACT_ATTACK: return 8'd60;
      default:    return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] clip_frames(input action_t clip);
    case (clip)
      ACT_WALK:   return 3'd4;
      ACT_ATTACK: return 3'd3;
      default:    return 3'd2;
    endcase
  endfunction

  function automatic clip_mode_t clip_mode(input action_t clip);
    case (clip)
      ACT_JUMP:   return HOLD;
      ACT_ATTACK: return LOCK;
      default:    return LOOP;
    endcase
  endfunction

endpackage

// File: rtl/sprite_anim_sequencer_if.sv
// Player-side bus of the sprite animation sequencer; ANIM_FLIP_EN adds the mirror pair.
interface sprite_anim_if;
  logic       frame_start;
  logic [2:0] action_req;
  logic [7:0] anim_row;
  logic [7:0] anim_col;
  logic       anim_tick;
  logic       anim_done;
  logic       busy;
`ifdef ANIM_FLIP_EN
  logic       facing_left;
  logic       anim_flip;
`endif

  modport master (
    output frame_start, action_req,
`ifdef ANIM_FLIP_EN
    output facing_left,
    input  anim_flip,
`endif
    input  anim_row, anim_col, anim_tick, anim_done, busy
  );

  modport slave (
    input  frame_start, action_req,
`ifdef ANIM_FLIP_EN
    input  facing_left,
    output anim_flip,
`endif
    output anim_row, anim_col, anim_tick, anim_done, busy
  );
endinterface

// File: rtl/sprite_anim_sequencer_tick_div.sv
// Divides video frame pulses down to the animation step pulse.
module anim_tick_div #(
  parameter int FRAMES_PER_TICK = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  input  logic clear,
  output logic anim_tick
);

  logic [4:0] tick_cnt_r;
  logic       tick_r;

  // Frame counter and registered step pulse; clear restarts the cell period.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      tick_cnt_r <= 5'd0;
      tick_r     <= 1'b0;
    end else if (frame_start) begin
      if (tick_cnt_r == 5'(FRAMES_PER_TICK - 1)) begin
        tick_cnt_r <= 5'd0;
        tick_r     <= 1'b1;
      end else begin
        tick_cnt_r <= tick_cnt_r + 5'd1;
        tick_r     <= 1'b0;
      end
    end else begin
      tick_cnt_r <= tick_cnt_r;
      tick_r     <= 1'b0;
    end
  end

  assign anim_tick = tick_r;

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Sprite animation sequencer: clip select, frame stepping, hold and lock handling.
// Optional mirror output built when ANIM_FLIP_EN is defined.
module sprite_anim_sequencer
  import sprite_anim_pkg::*;
#(
  parameter int FRAMES_PER_TICK = 6,
  parameter int CELL_W          = 23
) (
  input  logic         clk,
  input  logic         reset,
  sprite_anim_if.slave bus
);

  seq_state_t state_r, state_nxt_s;
  action_t    clip_r, clip_nxt_s, req_s;
  logic [1:0] frame_r, frame_nxt_s;
  logic [7:0] row_r, col_r;
  logic       done_r, done_nxt_s, busy_r;
  logic       tick_s, clip_change_s, last_s;

  anim_tick_div #(.FRAMES_PER_TICK(FRAMES_PER_TICK)) u_tick_div (
    .clk         (clk),
    .reset       (reset),
    .frame_start (bus.frame_start),
    .clear       (clip_change_s),
    .anim_tick   (tick_s)
  );

  assign req_s  = decode_action(bus.action_req);
  assign last_s = ({1'b0, frame_r} == (clip_frames(clip_r) - 3'd1));

  // Next clip/frame/state; a clip change takes priority over a coincident step.
  always_comb begin
    state_nxt_s   = state_r;
    clip_nxt_s    = clip_r;
    frame_nxt_s   = frame_r;
    done_nxt_s    = 1'b0;
    clip_change_s = 1'b0;
    case (state_r)
      S_RUN, S_HOLD: begin
        if (req_s != clip_r) begin
          clip_change_s = 1'b1;
          clip_nxt_s    = req_s;
          frame_nxt_s   = 2'd0;
          state_nxt_s   = (req_s == ACT_ATTACK) ? S_LOCK : S_RUN;
        end else if (tick_s && (state_r == S_RUN)) begin
          if (last_s && (clip_mode(clip_r) == HOLD)) begin
            state_nxt_s = S_HOLD;
            done_nxt_s  = 1'b1;
          end else if (last_s) begin
            frame_nxt_s = 2'd0;
          end else begin
            frame_nxt_s = frame_r + 2'd1;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_LOCK: begin
        if (tick_s && last_s) begin
          done_nxt_s  = 1'b1;
          clip_nxt_s  = req_s;
          frame_nxt_s = 2'd0;
          state_nxt_s = (req_s == ACT_ATTACK) ? S_LOCK : S_RUN;
        end else if (tick_s) begin
          frame_nxt_s = frame_r + 2'd1;
        end else begin
          frame_nxt_s = frame_r;
        end
      end
      default: begin
        state_nxt_s = S_RUN;
        clip_nxt_s  = ACT_IDLE;
        frame_nxt_s = 2'd0;
      end
    endcase
  end

  // Sequencer state and registered cell origin, aligned with the new clip/frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_RUN;
      clip_r  <= ACT_IDLE;
      frame_r <= 2'd0;
      row_r   <= 8'd0;
      col_r   <= 8'd0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      clip_r  <= clip_nxt_s;
      frame_r <= frame_nxt_s;
      row_r   <= clip_row(clip_nxt_s);
      col_r   <= 8'(frame_nxt_s) * 8'(CELL_W);
      done_r  <= done_nxt_s;
      busy_r  <= (state_nxt_s == S_LOCK);
    end
  end

  assign bus.anim_row  = row_r;
  assign bus.anim_col  = col_r;
  assign bus.anim_tick = tick_s;
  assign bus.anim_done = done_r;
  assign bus.busy      = busy_r;

`ifdef ANIM_FLIP_EN
  logic flip_r;

  // Mirror is latched only at cell boundaries so a cell never flips mid-display.
  always_ff @(posedge clk) begin
    if (reset) begin
      flip_r <= 1'b0;
    end else if (tick_s || clip_change_s) begin
      flip_r <= bus.facing_left;
    end else begin
      flip_r <= flip_r;
    end
  end

  assign bus.anim_flip = flip_r;
`endif

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Directed testbench for sprite_anim_sequencer (FRAMES_PER_TICK=6, CELL_W=23).
module tb_sprite_anim_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sprite_anim_if bus_if ();

  sprite_anim_sequencer #(.FRAMES_PER_TICK(6), .CELL_W(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One video frame: pulse cycle then idle cycle; reports tick, done, col while ticking.
  task automatic frame_pulse(output logic t, output logic d, output logic [7:0] col_t);
    bus_if.frame_start = 1'b1;
    cyc();
    t     = bus_if.anim_tick;
    d     = bus_if.anim_done;
    col_t = bus_if.anim_col;
    bus_if.frame_start = 1'b0;
    cyc();
    t = t | bus_if.anim_tick;
    d = d | bus_if.anim_done;
  endtask

  task automatic run_frames(input int n, output int ticks, output int dones);
    logic t, d;
    logic [7:0] c;
    ticks = 0;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      frame_pulse(t, d, c);
      if (t) ticks++;
      if (d) dones++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.action_req = 3'd0;
    bus_if.frame_start = 1'b0;
    cyc(); cyc();
    checks++;
    if ({bus_if.anim_row, bus_if.anim_col, bus_if.anim_tick, bus_if.anim_done, bus_if.busy} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got row=%0d col=%0d tick=%b done=%b busy=%b expected all 0",
               bus_if.anim_row, bus_if.anim_col, bus_if.anim_tick, bus_if.anim_done, bus_if.busy);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_idle_loop();
    logic t, d;
    logic [7:0] c;
    logic [7:0] exp_col [4] = '{8'd0, 8'd23, 8'd0, 8'd23};
    int n = 0;
    for (int i = 0; i < 24; i++) begin
      frame_pulse(t, d, c);
      if (t) begin
        if (n < 4) begin
          checks++;
          if (c !== exp_col[n]) begin
            errors++;
            $display("FAIL idle_col[%0d]: got %0d expected %0d", n, c, exp_col[n]);
          end
        end
        n++;
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL idle_tick_count: got %0d expected 4", n); end
    checks++;
    if (bus_if.anim_row !== 8'd0 || bus_if.anim_col !== 8'd0) begin
      errors++;
      $display("FAIL idle_final: got row=%0d col=%0d expected row=0 col=0", bus_if.anim_row, bus_if.anim_col);
    end
  endtask

  task automatic test_walk();
    logic t, d;
    logic [7:0] c;
    logic [7:0] exp_col [4] = '{8'd23, 8'd46, 8'd69, 8'd0};
    int n = 0;
    bus_if.action_req = 3'd1;
    cyc();
    checks++;
    if (bus_if.anim_row !== 8'd30 || bus_if.anim_col !== 8'd0) begin
      errors++;
      $display("FAIL walk_start: got row=%0d col=%0d expected row=30 col=0", bus_if.anim_row, bus_if.anim_col);
    end
    for (int i = 0; i < 24; i++) begin
      frame_pulse(t, d, c);
      if (t && n < 4) begin
        checks++;
        if (bus_if.anim_col !== exp_col[n]) begin
          errors++;
          $display("FAIL walk_col[%0d]: got %0d expected %0d", n, bus_if.anim_col, exp_col[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL walk_tick_count: got %0d expected 4", n); end
  endtask

  task automatic test_jump_hold();
    int ticks, dones;
    bus_if.action_req = 3'd2;
    cyc();
    checks++;
    if (bus_if.anim_row !== 8'd150 || bus_if.anim_col !== 8'd0) begin
      errors++;
      $display("FAIL jump_start: got row=%0d col=%0d expected row=150 col=0", bus_if.anim_row, bus_if.anim_col);
    end
    run_frames(6, ticks, dones);
    checks++;
    if (bus_if.anim_col !== 8'd23 || dones != 0) begin
      errors++;
      $display("FAIL jump_frame1: got col=%0d done_count=%0d expected col=23 done_count=0", bus_if.anim_col, dones);
    end
    run_frames(6, ticks, dones);
    checks++;
    if (dones != 1 || bus_if.anim_col !== 8'd23) begin
      errors++;
      $display("FAIL jump_done: got done_count=%0d col=%0d expected 1 and 23", dones, bus_if.anim_col);
    end
    run_frames(12, ticks, dones);
    checks++;
    if (bus_if.anim_col !== 8'd23 || dones != 0 || ticks != 2) begin
      errors++;
      $display("FAIL jump_hold: got col=%0d done_count=%0d ticks=%0d expected 23 0 2", bus_if.anim_col, dones, ticks);
    end
    bus_if.action_req = 3'd3;
    cyc();
    checks++;
    if (bus_if.anim_row !== 8'd180 || bus_if.anim_col !== 8'd0) begin
      errors++;
      $display("FAIL fall_start: got row=%0d col=%0d expected row=180 col=0", bus_if.anim_row, bus_if.anim_col);
    end
  endtask

  task automatic test_attack_lock();
    int ticks, dones;
    bus_if.action_req = 3'd4;
    cyc();
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.anim_row !== 8'd60 || bus_if.anim_col !== 8'd0) begin
      errors++;
      $display("FAIL attack_start: got busy=%b row=%0d col=%0d expected 1 60 0", bus_if.busy, bus_if.anim_row, bus_if.anim_col);
    end
    run_frames(6, ticks, dones);
    bus_if.action_req = 3'd1;
    checks++;
    if (bus_if.anim_col !== 8'd23 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL attack_frame1: got col=%0d busy=%b expected 23 1", bus_if.anim_col, bus_if.busy);
    end
    run_frames(6, ticks, dones);
    checks++;
    if (bus_if.anim_row !== 8'd60 || bus_if.anim_col !== 8'd46 || bus_if.busy !== 1'b1 || dones != 0) begin
      errors++;
      $display("FAIL attack_locked: got row=%0d col=%0d busy=%b done_count=%0d expected 60 46 1 0",
               bus_if.anim_row, bus_if.anim_col, bus_if.busy, dones);
    end
    run_frames(6, ticks, dones);
    checks++;
    if (dones != 1 || bus_if.busy !== 1'b0 || bus_if.anim_row !== 8'd30 || bus_if.anim_col !== 8'd0) begin
      errors++;
      $display("FAIL attack_release: got done_count=%0d busy=%b row=%0d col=%0d expected 1 0 30 0",
               dones, bus_if.busy, bus_if.anim_row, bus_if.anim_col);
    end
  endtask

  task automatic test_change_beats_tick();
    int ticks, dones;
    run_frames(5, ticks, dones);
    bus_if.frame_start = 1'b1;
    bus_if.action_req  = 3'd0;
    cyc();
    checks++;
    if (bus_if.anim_tick !== 1'b0 || bus_if.anim_row !== 8'd0 || bus_if.anim_col !== 8'd0) begin
      errors++;
      $display("FAIL change_vs_tick: got tick=%b row=%0d col=%0d expected 0 0 0", bus_if.anim_tick, bus_if.anim_row, bus_if.anim_col);
    end
    bus_if.frame_start = 1'b0;
    cyc();
    checks++;
    if (bus_if.anim_tick !== 1'b0 || bus_if.anim_col !== 8'd0) begin
      errors++;
      $display("FAIL change_vs_tick_after: got tick=%b col=%0d expected 0 0", bus_if.anim_tick, bus_if.anim_col);
    end
    run_frames(5, ticks, dones);
    checks++;
    if (ticks != 0) begin errors++; $display("FAIL divider_cleared: got %0d ticks in 5 frames expected 0", ticks); end
    run_frames(1, ticks, dones);
    checks++;
    if (ticks != 1 || bus_if.anim_col !== 8'd23) begin
      errors++;
      $display("FAIL divider_restart: got ticks=%0d col=%0d expected 1 23", ticks, bus_if.anim_col);
    end
  endtask

  task automatic test_back_to_back();
    int ticks, dones;
    bus_if.action_req = 3'd4;
    cyc();
    run_frames(18, ticks, dones);
    checks++;
    if (dones != 1 || bus_if.busy !== 1'b1 || bus_if.anim_row !== 8'd60 || bus_if.anim_col !== 8'd0) begin
      errors++;
      $display("FAIL relock: got done_count=%0d busy=%b row=%0d col=%0d expected 1 1 60 0",
               dones, bus_if.busy, bus_if.anim_row, bus_if.anim_col);
    end
  endtask

  task automatic test_reset_in_lock();
    int ticks, dones;
    run_frames(6, ticks, dones);
    checks++;
    if (bus_if.anim_col !== 8'd23 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL lock_before_reset: got col=%0d busy=%b expected 23 1", bus_if.anim_col, bus_if.busy);
    end
    reset = 1'b1;
    bus_if.action_req = 3'd0;
    cyc();
    checks++;
    if (bus_if.anim_row !== 8'd0 || bus_if.anim_col !== 8'd0 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_lock: got row=%0d col=%0d busy=%b expected 0 0 0", bus_if.anim_row, bus_if.anim_col, bus_if.busy);
    end
    reset = 1'b0;
    cyc();
  endtask

`ifdef ANIM_FLIP_EN
  task automatic test_flip();
    int ticks, dones;
    bus_if.facing_left = 1'b1;
    cyc(); cyc(); cyc();
    checks++;
    if (bus_if.anim_flip !== 1'b0) begin errors++; $display("FAIL flip_between_ticks: got %b expected 0", bus_if.anim_flip); end
    run_frames(6, ticks, dones);
    checks++;
    if (bus_if.anim_flip !== 1'b1) begin errors++; $display("FAIL flip_on_tick: got %b expected 1", bus_if.anim_flip); end
    bus_if.facing_left = 1'b0;
    cyc();
    checks++;
    if (bus_if.anim_flip !== 1'b1) begin errors++; $display("FAIL flip_hold: got %b expected 1", bus_if.anim_flip); end
    bus_if.action_req = 3'd1;
    cyc();
    checks++;
    if (bus_if.anim_flip !== 1'b0) begin errors++; $display("FAIL flip_on_change: got %b expected 0", bus_if.anim_flip); end
  endtask
`endif

  initial begin
    bus_if.frame_start = 1'b0;
    bus_if.action_req  = 3'd0;
`ifdef ANIM_FLIP_EN
    bus_if.facing_left = 1'b0;
`endif
    test_reset();
    test_idle_loop();
    test_walk();
    test_jump_hold();
    test_attack_lock();
    test_change_beats_tick();
    test_back_to_back();
    test_reset_in_lock();
`ifdef ANIM_FLIP_EN
    test_flip();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
